// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB master bridge.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StResp   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge.sv
// Converts a valid/ready command stream into single APB transfers, one at a time,
// returning read data or a timeout error on a valid/ready response channel.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              prst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_e        r_state,     w_state_nxt;
    logic              r_req_ready, w_req_ready_nxt;
    logic              r_psel,      w_psel_nxt;
    logic              r_penable,   w_penable_nxt;
    logic              r_pwrite,    w_pwrite_nxt;
    logic [ADDR_W-1:0] r_paddr,     w_paddr_nxt;
    logic [DATA_W-1:0] r_pwdata,    w_pwdata_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic              r_rsp_err,   w_rsp_err_nxt;
    logic [CNT_W-1:0]  r_cnt,       w_cnt_nxt;

    always_comb begin
        w_state_nxt     = r_state;
        w_req_ready_nxt = r_req_ready;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_pwrite_nxt    = r_pwrite;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_cnt_nxt       = r_cnt;

        unique case (r_state)
            StIdle: begin
                if (req_valid && r_req_ready) begin
                    w_state_nxt     = StSetup;
                    w_req_ready_nxt = 1'b0;
                    w_psel_nxt      = 1'b1;
                    w_pwrite_nxt    = req_write;
                    w_paddr_nxt     = req_addr;
                    w_pwdata_nxt    = req_wdata;
                end
            end
            StSetup: begin
                w_state_nxt   = StAccess;
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = '0;
            end
            StAccess: begin
                // PREADY takes priority over an expiring counter on the same edge.
                if (PREADY || (r_cnt == CNT_LAST)) begin
                    w_state_nxt     = StResp;
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = !PREADY;
                    w_rsp_rdata_nxt = (PREADY && !r_pwrite) ? PRDATA : '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    w_state_nxt     = StIdle;
                    w_rsp_valid_nxt = 1'b0;
                    w_req_ready_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_state     <= StIdle;
            r_req_ready <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;

endmodule
